// File: rtl/cmd_auth.sv
// cmd_auth: 8N1 UART command receiver plus power-authorization FSM.
// 'G' powers up the motor drive; 'S' powers it down, but only once the rider is off.
// Optional feature macro: CMD_AUTH_STOP_CHK_EN enables stop-bit checking
// (frm_err pulse and break wait). Without it the stop bit is ignored.
module cmd_auth #(
  parameter int         BAUD_CNT = 2604,
  parameter logic [7:0] G_CMD    = 8'h47,
  parameter logic [7:0] S_CMD    = 8'h53
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       rider_off,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       frm_err,
  output logic       pwr_up
);

  // The counter expires at 0, so the load cycle counts as one clock.
  // Loading N-1 therefore gives an interval of exactly N clocks.
  localparam logic [11:0] FULL_RELOAD = 12'(BAUD_CNT - 1);
  localparam logic [11:0] HALF_RELOAD = 12'(BAUD_CNT / 2 - 1);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'b00,
    RX_START = 2'b01,
    RX_DATA  = 2'b10,
    RX_STOP  = 2'b11
  } rx_state_e;

  // Bit 0 of the encoding is the power authorization itself, so pwr_up is
  // a straight flop output with no decode glitches.
  typedef enum logic [1:0] {
    AUTH_OFF  = 2'b00,
    AUTH_PWR1 = 2'b01,
    AUTH_PWR2 = 2'b11
  } auth_state_e;

  // Input synchronizer and edge detector
  logic rx_ff1_q, rx_ff2_q, rx_ff3_q;
  logic edge_q;
  logic fall_det;
  logic start_det;

  // Receiver
  rx_state_e   rx_state_q, rx_state_d;
  logic [11:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_rdy_q, rx_rdy_d;
  logic        baud_exp;

  // Authorization
  auth_state_e auth_q, auth_d;
  logic        cmd_g, cmd_s;

  assign fall_det = rx_ff3_q & ~rx_ff2_q;
  // An edge seen in the final cycle of a frame (while still in STOP) is
  // remembered for one cycle, so IDLE still starts if the line is low.
  assign start_det = fall_det | (edge_q & ~rx_ff2_q);
  assign baud_exp  = (baud_cnt_q == 12'd0);

  // Two-flop synchronizer plus edge-history flop, all preset to the idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1_q <= 1'b1;
      rx_ff2_q <= 1'b1;
      rx_ff3_q <= 1'b1;
      edge_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge value; blocking here would collapse the synchronizer chain into one stage.
      rx_ff1_q <= RX;
      rx_ff2_q <= rx_ff1_q;
      rx_ff3_q <= rx_ff2_q;
      edge_q   <= fall_det;
    end
  end

`ifdef CMD_AUTH_STOP_CHK_EN
  logic frm_err_q, frm_err_d;
  logic brk_q, brk_d;

  // Framing-error pulse and break-wait flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_err_q <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      frm_err_q <= frm_err_d;
      brk_q     <= brk_d;
    end
  end

  assign frm_err = frm_err_q;
`else
  assign frm_err = 1'b0;
`endif

  // Receiver state register and datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      baud_cnt_q <= 12'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      // NOTE: rx_data is a visible output that must read 0 after reset, so it is reset like any control flop rather than left as uninitialised storage.
      rx_data_q  <= 8'h00;
      rx_rdy_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_rdy_q   <= rx_rdy_d;
    end
  end

  // Receiver next-state: start qualification, mid-bit sampling, stop handling.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    rx_state_d = rx_state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_rdy_d   = 1'b0;
`ifdef CMD_AUTH_STOP_CHK_EN
    frm_err_d  = 1'b0;
    brk_d      = brk_q;
`endif
    case (rx_state_q)
      RX_IDLE: begin
        if (start_det) begin
          baud_cnt_d = HALF_RELOAD;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (baud_exp) begin
          if (rx_ff2_q) begin
            rx_state_d = RX_IDLE;           // glitch: line back high at mid-bit
          end else begin
            baud_cnt_d = FULL_RELOAD;
            bit_cnt_d  = 3'd0;
            rx_state_d = RX_DATA;
          end
        end else begin
          baud_cnt_d = baud_cnt_q - 12'd1;
        end
      end
      RX_DATA: begin
        if (baud_exp) begin
          shift_d    = {rx_ff2_q, shift_q[7:1]};   // LSB first
          baud_cnt_d = FULL_RELOAD;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d  = 3'd0;
            rx_state_d = RX_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q - 12'd1;
        end
      end
      RX_STOP: begin
`ifdef CMD_AUTH_STOP_CHK_EN
        if (brk_q) begin
          // Hold here through a break so its low level is not taken as a start bit.
          if (rx_ff2_q) begin
            brk_d      = 1'b0;
            rx_state_d = RX_IDLE;
          end
        end else if (baud_exp) begin
          if (rx_ff2_q) begin
            rx_data_d  = shift_q;
            rx_rdy_d   = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            frm_err_d = 1'b1;
            brk_d     = 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q - 12'd1;
        end
`else
        if (baud_exp) begin
          rx_data_d  = shift_q;
          rx_rdy_d   = 1'b1;
          rx_state_d = RX_IDLE;
        end else begin
          baud_cnt_d = baud_cnt_q - 12'd1;
        end
`endif
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign cmd_g = rx_rdy_q && (rx_data_q == G_CMD);
  assign cmd_s = rx_rdy_q && (rx_data_q == S_CMD);

  // Authorization state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) auth_q <= AUTH_OFF;
    else        auth_q <= auth_d;
  end

  // Authorization next-state: stop is deferred until the rider steps off.
  always_comb begin
    auth_d = auth_q;
    case (auth_q)
      AUTH_OFF:  if (cmd_g) auth_d = AUTH_PWR1;
      AUTH_PWR1: if (cmd_s) auth_d = rider_off ? AUTH_OFF : AUTH_PWR2;
      AUTH_PWR2: begin
        if (rider_off)  auth_d = AUTH_OFF;     // rider leaving wins over a new 'G'
        else if (cmd_g) auth_d = AUTH_PWR1;
      end
      default:   auth_d = AUTH_OFF;
    endcase
  end

  assign rx_data = rx_data_q;
  assign rx_rdy  = rx_rdy_q;
  assign pwr_up  = auth_q[0];

endmodule

// File: tb/tb_cmd_auth.sv
// Testbench for cmd_auth. Uses a short bit period so that many frames fit
// in a short run. Received bytes are checked against a scoreboard, including
// the start-edge-to-rx_rdy latency. Build with +define+CMD_AUTH_STOP_CHK_EN
// to exercise the stop-bit check.
module tb_cmd_auth;

  localparam int B   = 64;                 // clocks per bit for this bench
  localparam int LAT = 3 + B / 2 + 9 * B;  // start edge on pin -> rx_rdy

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       RX = 1'b1;
  logic       rider_off = 1'b0;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       frm_err;
  logic       pwr_up;

  cmd_auth #(.BAUD_CNT(B)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RX        (RX),
    .rider_off (rider_off),
    .rx_data   (rx_data),
    .rx_rdy    (rx_rdy),
    .frm_err   (frm_err),
    .pwr_up    (pwr_up)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [7:0] data;
    int         start;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   rdy_cnt = 0;
  int   ferr_cnt = 0;
  logic rdy_prev = 1'b0;
  logic ferr_prev = 1'b0;

  // Monitor: pops the scoreboard on every rx_rdy and checks pulse widths.
  always @(negedge clk) begin
    if (rdy_prev) begin
      checks++;
      if (rx_rdy !== 1'b0) $display("FAIL rdy_width: rx_rdy=%b on 2nd cycle, required 0", rx_rdy);
      else passed++;
    end
    if (ferr_prev) begin
      checks++;
      if (frm_err !== 1'b0) $display("FAIL ferr_width: frm_err=%b on 2nd cycle, required 0", frm_err);
      else passed++;
    end
    if (rx_rdy === 1'b1) begin
      rdy_cnt++;
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected: rx_rdy with rx_data=%02h, required no pulse", rx_data);
      end else begin
        passed++;
        mon_e = sb.pop_front();
        checks++;
        if (rx_data !== mon_e.data) $display("FAIL sb_data: rx_data=%02h, required %02h", rx_data, mon_e.data);
        else passed++;
        checks++;
        if ((cyc - mon_e.start) < LAT - 1 || (cyc - mon_e.start) > LAT + 1)
          $display("FAIL sb_latency: %0d clocks, required %0d +/-1", cyc - mon_e.start, LAT);
        else passed++;
      end
    end
    if (frm_err === 1'b1) ferr_cnt++;
    rdy_prev  = (rx_rdy === 1'b1);
    ferr_prev = (frm_err === 1'b1);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  // Drive one 8N1 frame; optionally push the expected byte to the scoreboard.
  task automatic send_byte(input logic [7:0] d, input logic stop_val, input bit expect_rdy);
    exp_t e;
    @(negedge clk);
    if (expect_rdy) begin
      e.data  = d;
      e.start = cyc;
      sb.push_back(e);
    end
    RX = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = d[i];
      repeat (B) @(negedge clk);
    end
    RX = stop_val;
    repeat (B) @(negedge clk);
    RX = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: %02h, required 00", rx_data); else passed++;
    checks++; if (rx_rdy !== 1'b0)   $display("FAIL reset_rx_rdy: %b, required 0", rx_rdy);      else passed++;
    checks++; if (frm_err !== 1'b0)  $display("FAIL reset_frm_err: %b, required 0", frm_err);    else passed++;
    checks++; if (pwr_up !== 1'b0)   $display("FAIL reset_pwr_up: %b, required 0", pwr_up);      else passed++;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_go();
    rider_off = 1'b0;
    fork
      send_byte(8'h47, 1'b1, 1'b1);
      begin
        bit got;
        got = 1'b0;
        for (int k = 0; k < 12 * B && !got; k++) begin
          @(negedge clk);
          if (rx_rdy === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got) $display("FAIL go_rdy_timeout: no rx_rdy, required one");
        else passed++;
        if (got) begin
          checks++;
          if (pwr_up !== 1'b0) $display("FAIL go_pwr_at_rdy: %b, required 0", pwr_up); else passed++;
          @(negedge clk);
          checks++;
          if (pwr_up !== 1'b1) $display("FAIL go_pwr_after_rdy: %b, required 1", pwr_up); else passed++;
        end
      end
    join
  endtask

  task automatic test_stop_pending();
    rider_off = 1'b0;
    send_byte(8'h53, 1'b1, 1'b1);
    checks++; if (pwr_up !== 1'b1) $display("FAIL pend_pwr2: %b, required 1", pwr_up); else passed++;
    @(negedge clk);
    rider_off = 1'b1;
    #1;
    checks++; if (pwr_up !== 1'b1) $display("FAIL pend_before_edge: %b, required 1", pwr_up); else passed++;
    @(negedge clk);
    checks++; if (pwr_up !== 1'b0) $display("FAIL pend_rider_off: %b, required 0", pwr_up); else passed++;
    rider_off = 1'b0;
  endtask

  task automatic test_stop_immediate();
    send_byte(8'h47, 1'b1, 1'b1);
    checks++; if (pwr_up !== 1'b1) $display("FAIL imm_go: %b, required 1", pwr_up); else passed++;
    @(negedge clk);
    rider_off = 1'b1;
    send_byte(8'h53, 1'b1, 1'b1);
    checks++; if (pwr_up !== 1'b0) $display("FAIL imm_stop: %b, required 0", pwr_up); else passed++;
    @(negedge clk);
    rider_off = 1'b0;
    send_byte(8'h47, 1'b1, 1'b1);
    send_byte(8'h53, 1'b1, 1'b1);
    checks++; if (pwr_up !== 1'b1) $display("FAIL cancel_pwr2: %b, required 1", pwr_up); else passed++;
    send_byte(8'h47, 1'b1, 1'b1);
    checks++; if (pwr_up !== 1'b1) $display("FAIL cancel_pwr1: %b, required 1", pwr_up); else passed++;
    // Back in PWR1, rider_off alone must not drop power.
    @(negedge clk);
    rider_off = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (pwr_up !== 1'b1) $display("FAIL cancel_ignores_rider: %b, required 1", pwr_up); else passed++;
    rider_off = 1'b0;
  endtask

  task automatic test_glitch();
    int n0, f0;
    n0 = rdy_cnt;
    f0 = ferr_cnt;
    @(negedge clk);
    RX = 1'b0;
    repeat (B / 4) @(negedge clk);
    RX = 1'b1;
    repeat (2 * B) @(negedge clk);
    checks++; if (rdy_cnt !== n0)  $display("FAIL glitch_rdy: %0d pulses, required %0d", rdy_cnt, n0); else passed++;
    checks++; if (ferr_cnt !== f0) $display("FAIL glitch_ferr: %0d pulses, required %0d", ferr_cnt, f0); else passed++;
    send_byte(8'h41, 1'b1, 1'b1);
    checks++; if (rdy_cnt !== n0 + 1) $display("FAIL other_rdy: %0d pulses, required %0d", rdy_cnt, n0 + 1); else passed++;
    checks++; if (pwr_up !== 1'b1)    $display("FAIL other_pwr: %b, required 1", pwr_up); else passed++;
  endtask

  task automatic test_frame_err();
    int n0, f0;
    @(negedge clk);
    rider_off = 1'b1;
    send_byte(8'h53, 1'b1, 1'b1);
    checks++; if (pwr_up !== 1'b0) $display("FAIL ferr_setup_pwr: %b, required 0", pwr_up); else passed++;
    @(negedge clk);
    rider_off = 1'b0;
    n0 = rdy_cnt;
    f0 = ferr_cnt;
`ifdef CMD_AUTH_STOP_CHK_EN
    send_byte(8'h47, 1'b0, 1'b0);
    repeat (B) @(negedge clk);
    checks++; if (ferr_cnt !== f0 + 1) $display("FAIL ferr_pulse: %0d pulses, required %0d", ferr_cnt, f0 + 1); else passed++;
    checks++; if (rdy_cnt !== n0)      $display("FAIL ferr_no_rdy: %0d pulses, required %0d", rdy_cnt, n0); else passed++;
    checks++; if (pwr_up !== 1'b0)     $display("FAIL ferr_pwr: %b, required 0", pwr_up); else passed++;
`else
    send_byte(8'h47, 1'b0, 1'b1);
    repeat (B) @(negedge clk);
    checks++; if (ferr_cnt !== f0)     $display("FAIL ferr_tied: %0d pulses, required %0d", ferr_cnt, f0); else passed++;
    checks++; if (rdy_cnt !== n0 + 1)  $display("FAIL ferr_rdy: %0d pulses, required %0d", rdy_cnt, n0 + 1); else passed++;
    checks++; if (pwr_up !== 1'b1)     $display("FAIL ferr_pwr: %b, required 1", pwr_up); else passed++;
`endif
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    d = 8'hA5;
    rider_off = 1'b0;
    send_byte(8'h47, 1'b1, 1'b1);
    checks++; if (pwr_up !== 1'b1) $display("FAIL rst_setup_pwr: %b, required 1", pwr_up); else passed++;
    @(negedge clk);
    RX = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      RX = d[i];
      repeat (B) @(negedge clk);
    end
    RX = d[4];
    repeat (B / 2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pwr_up !== 1'b0)    $display("FAIL rst_pwr: %b, required 0", pwr_up); else passed++;
    checks++; if (rx_data !== 8'h00)  $display("FAIL rst_rx_data: %02h, required 00", rx_data); else passed++;
    checks++; if (rx_rdy !== 1'b0)    $display("FAIL rst_rx_rdy: %b, required 0", rx_rdy); else passed++;
    repeat (2) @(negedge clk);
    RX = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (B) @(negedge clk);
    checks++; if (pwr_up !== 1'b0) $display("FAIL rst_after_release: %b, required 0", pwr_up); else passed++;
    send_byte(8'h47, 1'b1, 1'b1);
    checks++; if (pwr_up !== 1'b1) $display("FAIL rst_clean_go: %b, required 1", pwr_up); else passed++;
  endtask

  task automatic test_back_to_back();
    int n0;
    n0 = rdy_cnt;
    send_byte(8'h41, 1'b1, 1'b1);
    send_byte(8'h42, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (rdy_cnt !== n0 + 2) $display("FAIL b2b_count: %0d pulses, required %0d", rdy_cnt, n0 + 2); else passed++;
    checks++; if (rx_data !== 8'h42)  $display("FAIL b2b_last: %02h, required 42", rx_data); else passed++;
    checks++; if (pwr_up !== 1'b1)    $display("FAIL b2b_pwr: %b, required 1", pwr_up); else passed++;
  endtask

  initial begin
    test_reset();
    test_go();
    test_stop_pending();
    test_stop_immediate();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_back_to_back();
    repeat (10) @(negedge clk);
    checks++;
    if (sb.size() != 0) $display("FAIL sb_leftover: %0d bytes never received, required 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/cmd_auth.md
# cmd_auth

UART command receiver and power-authorization FSM, directly downstream of the BLE module's serial line (`RX`) and upstream of the balance controller's enable. It deserializes 8N1 bytes at 19200 baud. It decodes `'G'` (go) and `'S'` (stop). It maintains `pwr_up`, which gates motor drive. A stop request is honoured only once the rider has stepped off.

## Interface
- `BAUD_CNT`, 2604: clocks per bit (50 MHz / 19200).
- `G_CMD`, 8'h47: power-up command byte.
- `S_CMD`, 8'h53: power-down command byte.

- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `RX` in 1: serial input; idle high; asynchronous to `clk`.
- `rider_off` in 1: high when summed load cell is below the rider threshold; synchronous.
- `rx_data` out 8: last correctly received byte; held until the next `rx_rdy`.
- `rx_rdy` out 1: one-cycle pulse when a byte is accepted.
- `frm_err` out 1: one-cycle pulse on stop-bit error.
- `pwr_up` out 1: power authorization to the balance controller.

## Operation
- **RX input conditioning**
  - `RX` passes through two flops preset to 1 on reset.
  - The falling-edge detector uses a third flop, also preset to 1.
- **Receiver FSM**
  - States: IDLE, START, DATA, STOP.
  - IDLE: on a synced falling edge, load the baud counter with `BAUD_CNT/2` and go to START.
  - START: when the counter expires, sample the line.
    - Line high: glitch; return to IDLE, no pulse.
    - Line low: load `BAUD_CNT` and go to DATA.
  - DATA: sample 8 bits LSB first, one every `BAUD_CNT` clocks, into a shift register; bit counter runs 0..7. After bit 7, go to STOP.
  - STOP: sample at mid-bit.
    - Stop = 1: copy the shift register to `rx_data`, pulse `rx_rdy`, return to IDLE.
    - Stop = 0: see Configuration.
- **Authorization FSM**
  - States: OFF, PWR1 (powered, no stop pending), PWR2 (stop pending).
  - OFF: `rx_rdy` with `G_CMD` → PWR1.
  - PWR1:
    - `rx_rdy` with `S_CMD` and `rider_off` → OFF.
    - `rx_rdy` with `S_CMD` and `!rider_off` → PWR2.
  - PWR2:
    - `rider_off` → OFF.
    - `rx_rdy` with `G_CMD` → PWR1 (cancels the pending stop); `rider_off` takes priority if both occur in the same cycle.
  - All other bytes are ignored in every state. `G` in PWR1 and `S` in OFF/PWR2 are no-ops.
  - `pwr_up` = (state != OFF), driven from the state register (glitch-free).
- **Boundary behaviour**
  - No buffering: a new byte overwrites `rx_data` at its own `rx_rdy`.
  - A start edge arriving in the same cycle as STOP completion is recognised in the next cycle from IDLE, because the line is still low.
  - Reset asserted mid-byte or mid-state: both FSMs return to IDLE/OFF immediately. The partial byte is discarded and `rx_data` is cleared.

## Timing
- Reset values:
  - `rx_data` = 0, `rx_rdy` = 0, `frm_err` = 0, `pwr_up` = 0.
  - Sync flops = 1; all counters = 0.
- Input latency: edge detection occurs 3 clocks after the `RX` pin falls.
- `rx_rdy` timing:
  - Asserts 3 + `BAUD_CNT/2` + 9·`BAUD_CNT` clocks after the start-bit falling edge on the pin (24741 at default), ±1 clock.
  - Pulse width is exactly 1 cycle.
- `pwr_up` changes on the clock edge after the `rx_rdy` cycle (1-cycle latency).
- `pwr_up` falls 1 cycle after `rider_off` is sampled high in PWR2.
- The baud counter is 12 bits; expiry is at count 0, then reload. There is no free-running wrap.

## Configuration
- `CMD_AUTH_STOP_CHK_EN` defined:
  - Stop bit = 0 → `frm_err` pulses for 1 cycle.
  - No `rx_rdy`; `rx_data` and the auth FSM are unchanged.
  - Receiver waits in STOP until the line returns high, then goes to IDLE, preventing a false start inside a break.
- Undefined:
  - The stop bit is sampled but ignored; every completed frame produces `rx_rdy`.
  - `frm_err` is tied to 0.

## Test plan
- Reset, then send `0x47` → `rx_rdy` pulses once with `rx_data`=`0x47` ~24741 clocks after the start edge; `pwr_up` goes 0→1 the next cycle.
- `pwr_up`=1, `rider_off`=0, send `0x53` → `pwr_up` stays 1 (PWR2). Raise `rider_off` → `pwr_up`=0 one cycle later.
- `pwr_up`=1, `rider_off`=1, send `0x53` → `pwr_up`=0 one cycle after `rx_rdy`. In PWR2, send `0x47` → returns to PWR1, `pwr_up` stays 1.
- `RX` low for 500 clocks then high → no `rx_rdy`, no `frm_err`. Send `0x41` → `rx_rdy` with `0x41`, `pwr_up` unchanged.
- Frame `0x47` with stop bit forced 0 → with macro: `frm_err`=1 for 1 cycle, `pwr_up` stays 0. Without macro: `rx_rdy` pulses and `pwr_up`=1.
- `pwr_up`=1, then assert `rst_n`=0 during data bit 4 of a byte → `pwr_up`, `rx_data`, `rx_rdy` all 0 asynchronously. After release, a clean `0x47` is received correctly.
